wb_commit_monitor: RTL and testbench
====================================

WB_COMMIT_MONITOR -- requirements
Module: wb_commit_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >= 2).
REQ-002 SHALL have parameter TIMEOUT, default 64, number of idle cycles before a stall is flagged.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port clear, input, 1, synchronous soft clear with the same effect as reset.
REQ-006 SHALL have port wb_valid, input, 1, WB stage retires an instruction this cycle.
REQ-007 SHALL have port wb_we, input, 1, retiring instruction writes the register file.
REQ-008 SHALL have port wb_rd, input, 5, destination register.
REQ-009 SHALL have port wb_data, input, 32, write-back value.
REQ-010 SHALL have port wb_pc, input, 32, PC of the retiring instruction.
REQ-011 SHALL have port trace_valid, output, 1, a trace entry is available at the FIFO head.
REQ-012 SHALL have port trace_ready, input, 1, consumer accepts the head entry.
REQ-013 SHALL have port trace_pc / trace_rd / trace_we / trace_data, output, 32/5/1/32, head entry fields.
REQ-014 SHALL have port fill, output, $clog2(DEPTH)+1, current occupancy.
REQ-015 SHALL have port retired_count / drop_count / cycle_count, output, 32 each, statistics.
REQ-016 SHALL have port overflow / stall_timeout, output, 1 each, sticky error flags.

Function
REQ-017 SHALL push {wb_pc, wb_rd, wb_we, wb_data} on every cycle where wb_valid=1 and the FIFO is not full after accounting for a same-cycle pop.
REQ-018 SHALL drive trace_* from the head entry combinationally from registered storage (first-word fall-through); trace_valid = (fill != 0).
REQ-019 SHALL pop the head on a cycle where trace_valid=1 and trace_ready=1; trace_ready while empty has no effect.
REQ-020 SHALL make a pushed entry visible on trace_valid in the cycle after the push edge (1-cycle latency); no bypass when the FIFO is empty.
REQ-021 SHALL accept the push on simultaneous push and pop when full; fill stays DEPTH and no drop occurs.
REQ-022 SHALL, when wb_valid=1, the FIFO is full, and there is no pop, drop the entry, increment drop_count, and set overflow (sticky).
REQ-023 SHALL wrap the read and write pointers modulo DEPTH; fill tracks pushes minus pops exactly.
REQ-024 SHALL increment retired_count on every wb_valid=1 cycle, dropped or not; all counters saturate at 0xFFFFFFFF.
REQ-025 SHALL increment cycle_count every cycle when not in reset/clear.
REQ-026 SHALL keep an idle counter: reset to 0 on wb_valid=1, otherwise increment (saturating at TIMEOUT); stall_timeout is set sticky when the idle counter reaches TIMEOUT.
REQ-027 SHALL implement the watchdog as FSM states RUN, then STALLED: RUN->STALLED when idle=TIMEOUT; STALLED->RUN on wb_valid=1 (stall_timeout remains set); only reset/clear returns the flag to 0.
REQ-028 SHALL give reset/clear priority over all same-cycle push/pop activity.

Reset
REQ-029 SHALL, on reset or clear, set pointers, fill, all counters, idle counter, overflow, and stall_timeout to 0, set FSM to RUN, and force trace_valid=0 in the next cycle; storage contents need not clear.
REQ-030 SHALL discard any buffered entries on reset asserted mid-operation; no entry pushed before reset appears afterwards.

Verification
REQ-031 SHALL cover single push: wb_valid=1, pc=0x10, rd=5, data=0xAB for one cycle -> next cycle trace_valid=1, trace_pc=0x10, trace_rd=5, trace_data=0xAB, fill=1; with trace_ready=1, fill returns to 0 one cycle later.
REQ-032 SHALL cover overflow: 17 pushes with trace_ready=0, DEPTH=16 -> fill=16, drop_count=1, overflow=1, retired_count=17; drained order equals pushes 1..16.
REQ-033 SHALL cover full push+pop: fill=16, wb_valid=1, trace_ready=1 in the same cycle -> fill=16, drop_count unchanged, new entry is last on drain.
REQ-034 SHALL cover the watchdog: TIMEOUT=64, no wb_valid for 64 cycles -> stall_timeout=1; one retirement -> FSM RUN, flag still 1; clear -> flag 0.
REQ-035 SHALL cover reset mid-stream: 5 entries buffered, reset for 1 cycle -> fill=0, trace_valid=0, counters=0; a subsequent push of pc=0x40 is the first entry out.
REQ-036 SHALL cover pointer wrap: 40 push/pop pairs interleaved at fill between 1 and 3 -> all 40 entries drained in order with no drop.

Source files
------------

// File: rtl/wb_commit_monitor_if.sv
// Write-back retirement and trace-consumer signals of the commit monitor.
// The master side is the pipeline plus the trace consumer; the slave side is the monitor.
interface wb_commit_monitor_if;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_rd;
    logic        trace_we;
    logic [31:0] trace_data;

    modport master (
        output wb_valid, wb_we, wb_rd, wb_data, wb_pc, trace_ready,
        input  trace_valid, trace_pc, trace_rd, trace_we, trace_data
    );

    modport slave (
        input  wb_valid, wb_we, wb_rd, wb_data, wb_pc, trace_ready,
        output trace_valid, trace_pc, trace_rd, trace_we, trace_data
    );
endinterface

// File: rtl/wb_commit_monitor.sv
// Commit monitor: buffers every retiring instruction in a first-word
// fall-through trace FIFO, keeps saturating retirement/drop/cycle statistics,
// and runs an idle watchdog that raises a sticky stall flag.
module wb_commit_monitor #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    wb_commit_monitor_if.slave       bus,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [31:0]              retired_count,
    output logic [31:0]              drop_count,
    output logic [31:0]              cycle_count,
    output logic                     overflow,
    output logic                     stall_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);
    localparam logic [31:0]   CNT_MAX  = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        STALLED = 1'b1
    } wd_state_t;

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        sat_inc = (value == CNT_MAX) ? value : value + 32'd1;
    endfunction

    logic [31:0] mem_pc   [0:DEPTH-1];
    logic [4:0]  mem_rd   [0:DEPTH-1];
    logic        mem_we   [0:DEPTH-1];
    logic [31:0] mem_data [0:DEPTH-1];

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [FW-1:0] fill_r;
    logic [31:0]   retired_r;
    logic [31:0]   drop_r;
    logic [31:0]   cycle_r;
    logic          overflow_r;
    logic          stall_r;
    logic [IW-1:0] idle_r;
    wd_state_t     state_r;

    logic          flush_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [IW-1:0] idle_next_s;
    wd_state_t     state_next_s;

    // FIFO handshake decode; a pop frees a slot for a same-cycle push when full.
    always_comb begin
        flush_s = reset || clear;
        full_s  = (fill_r == FULL_LVL);
        pop_s   = (fill_r != {FW{1'b0}}) && bus.trace_ready;
        push_s  = bus.wb_valid && (!full_s || pop_s);
        drop_s  = bus.wb_valid && full_s && !pop_s;
    end

    // Idle counter next value and watchdog next state.
    always_comb begin
        idle_next_s  = idle_r;
        state_next_s = state_r;
        if (bus.wb_valid) begin
            idle_next_s = {IW{1'b0}};
        end else if (idle_r != IDLE_MAX) begin
            idle_next_s = idle_r + IW'(1);
        end else begin
            idle_next_s = idle_r;
        end
        case (state_r)
            RUN: begin
                if (idle_next_s == IDLE_MAX) begin
                    state_next_s = STALLED;
                end else begin
                    state_next_s = RUN;
                end
            end
            STALLED: begin
                if (bus.wb_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = STALLED;
                end
            end
            default: state_next_s = RUN;
        endcase
    end

    // Trace entry storage; contents are not cleared, validity comes from fill.
    always_ff @(posedge clk) begin
        if (push_s && !flush_s) begin
            mem_pc[wr_ptr_r]   <= bus.wb_pc;
            mem_rd[wr_ptr_r]   <= bus.wb_rd;
            mem_we[wr_ptr_r]   <= bus.wb_we;
            mem_data[wr_ptr_r] <= bus.wb_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            fill_r   <= {FW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   fill_r <= fill_r + FW'(1);
                2'b01:   fill_r <= fill_r - FW'(1);
                default: fill_r <= fill_r;
            endcase
        end
    end

    // Saturating statistics and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            retired_r  <= 32'd0;
            drop_r     <= 32'd0;
            cycle_r    <= 32'd0;
            overflow_r <= 1'b0;
        end else begin
            cycle_r <= sat_inc(cycle_r);
            if (bus.wb_valid) retired_r <= sat_inc(retired_r);
            if (drop_s) begin
                drop_r     <= sat_inc(drop_r);
                overflow_r <= 1'b1;
            end
        end
    end

    // Watchdog state, idle counter and sticky stall flag.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            state_r <= RUN;
            idle_r  <= {IW{1'b0}};
            stall_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            idle_r  <= idle_next_s;
            if (idle_next_s == IDLE_MAX) stall_r <= 1'b1;
        end
    end

    assign bus.trace_valid = (fill_r != {FW{1'b0}});
    assign bus.trace_pc    = mem_pc[rd_ptr_r];
    assign bus.trace_rd    = mem_rd[rd_ptr_r];
    assign bus.trace_we    = mem_we[rd_ptr_r];
    assign bus.trace_data  = mem_data[rd_ptr_r];

    assign fill          = fill_r;
    assign retired_count = retired_r;
    assign drop_count    = drop_r;
    assign cycle_count   = cycle_r;
    assign overflow      = overflow_r;
    assign stall_timeout = stall_r;
endmodule

// File: tb/tb_wb_commit_monitor.sv
// Bench for wb_commit_monitor: a queue-based model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_commit_monitor;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [4:0]  fill;
    logic [31:0] retired_count, drop_count, cycle_count;
    logic        overflow, stall_timeout;

    wb_commit_monitor_if bus();

    wb_commit_monitor #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus),
        .fill(fill), .retired_count(retired_count), .drop_count(drop_count),
        .cycle_count(cycle_count), .overflow(overflow), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int unsigned m_ret, m_drop, m_cyc, m_idle;
    bit          m_ovf, m_stall;
    bit          check_en = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model, then advance the model by the coming edge.
    always @(negedge clk) begin
        ent_t e;
        bit   do_pop, was_full;
        if (check_en) begin
            chk("trace_valid", {31'd0, bus.trace_valid}, {31'd0, q.size() != 0});
            chk("fill", {27'd0, fill}, q.size());
            if (q.size() != 0) begin
                chk("trace_pc", bus.trace_pc, q[0].pc);
                chk("trace_rd", {27'd0, bus.trace_rd}, {27'd0, q[0].rd});
                chk("trace_we", {31'd0, bus.trace_we}, {31'd0, q[0].we});
                chk("trace_data", bus.trace_data, q[0].data);
            end
            chk("retired_count", retired_count, m_ret);
            chk("drop_count", drop_count, m_drop);
            chk("cycle_count", cycle_count, m_cyc);
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_stall});
        end
        if (reset === 1'b1 || clear === 1'b1) begin
            q.delete();
            m_ret = 0; m_drop = 0; m_cyc = 0; m_idle = 0;
            m_ovf = 1'b0; m_stall = 1'b0;
        end else begin
            was_full = (q.size() == DEPTH);
            do_pop   = (q.size() != 0) && bus.trace_ready;
            if (do_pop) void'(q.pop_front());
            if (bus.wb_valid) begin
                if (m_ret != 32'hFFFF_FFFF) m_ret++;
                if (!was_full || do_pop) begin
                    e.pc = bus.wb_pc; e.rd = bus.wb_rd; e.we = bus.wb_we; e.data = bus.wb_data;
                    q.push_back(e);
                end else begin
                    if (m_drop != 32'hFFFF_FFFF) m_drop++;
                    m_ovf = 1'b1;
                end
                m_idle = 0;
            end else if (m_idle < TIMEOUT) begin
                m_idle++;
            end
            if (m_idle == TIMEOUT) m_stall = 1'b1;
            if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
        end
    end

    // Apply one cycle of inputs, return 1 time unit after the consuming edge.
    task automatic step(input logic v, input logic we, input logic [4:0] rd,
                        input logic [31:0] data, input logic [31:0] pc, input logic rdy);
        bus.wb_valid = v; bus.wb_we = we; bus.wb_rd = rd;
        bus.wb_data = data; bus.wb_pc = pc; bus.trace_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input logic rdy);
        step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, rdy);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        idle_step(1'b0);
        clear = 1'b0;
    endtask

    initial begin
        int popped;
        int pushed;
        reset = 1'b1;
        clear = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_we = 1'b0; bus.wb_rd = 5'd0;
        bus.wb_data = 32'd0; bus.wb_pc = 32'd0; bus.trace_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_en = 1'b1;
        reset = 1'b0;

        // Reset state
        chk("rst_trace_valid", {31'd0, bus.trace_valid}, 32'd0);
        chk("rst_fill", {27'd0, fill}, 32'd0);
        chk("rst_retired", retired_count, 32'd0);
        chk("rst_flags", {30'd0, overflow, stall_timeout}, 32'd0);

        // Single push, one-cycle visibility, pop
        step(1'b1, 1'b1, 5'd5, 32'hAB, 32'h10, 1'b0);
        chk("single_valid", {31'd0, bus.trace_valid}, 32'd1);
        chk("single_pc", bus.trace_pc, 32'h10);
        chk("single_rd", {27'd0, bus.trace_rd}, 32'd5);
        chk("single_data", bus.trace_data, 32'hAB);
        chk("single_fill", {27'd0, fill}, 32'd1);
        idle_step(1'b1);
        chk("single_fill_after_pop", {27'd0, fill}, 32'd0);

        // Overflow: 17 pushes into a 16-deep FIFO
        do_clear();
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 5'(i), 32'h5000 + i, 32'h100 + i, 1'b0);
        chk("ovf_fill", {27'd0, fill}, 32'd16);
        chk("ovf_drop", drop_count, 32'd1);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_retired", retired_count, 32'd17);

        // Full push+pop: accepted, no drop, goes to the tail
        step(1'b1, 1'b1, 5'd31, 32'hDEAD, 32'h999, 1'b1);
        chk("fullpp_fill", {27'd0, fill}, 32'd16);
        chk("fullpp_drop", drop_count, 32'd1);
        for (int i = 1; i < 16; i++) begin
            chk("drain_order", bus.trace_pc, 32'h100 + i);
            idle_step(1'b1);
        end
        chk("drain_last", bus.trace_pc, 32'h999);
        idle_step(1'b1);
        chk("drain_empty", {27'd0, fill}, 32'd0);

        // Watchdog
        do_clear();
        repeat (TIMEOUT - 1) idle_step(1'b0);
        chk("wd_not_yet", {31'd0, stall_timeout}, 32'd0);
        idle_step(1'b0);
        chk("wd_flag", {31'd0, stall_timeout}, 32'd1);
        step(1'b1, 1'b0, 5'd1, 32'd1, 32'h20, 1'b1);
        chk("wd_sticky", {31'd0, stall_timeout}, 32'd1);
        do_clear();
        chk("wd_cleared", {31'd0, stall_timeout}, 32'd0);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 5'd2, 32'd7 + i, 32'h300 + i, 1'b0);
        reset = 1'b1;
        idle_step(1'b0);
        reset = 1'b0;
        chk("mid_rst_fill", {27'd0, fill}, 32'd0);
        chk("mid_rst_valid", {31'd0, bus.trace_valid}, 32'd0);
        chk("mid_rst_counts", retired_count | drop_count | cycle_count, 32'd0);
        step(1'b1, 1'b1, 5'd3, 32'h44, 32'h40, 1'b0);
        chk("mid_rst_first", bus.trace_pc, 32'h40);

        // Pointer wrap: 40 entries at fill 1..3
        do_clear();
        popped = 0;
        pushed = 0;
        while (popped < 40 && pushed < 200) begin
            logic rdy;
            rdy = (fill >= 5'd2) || (pushed >= 40);
            if (rdy && bus.trace_valid) begin
                chk("wrap_order", bus.trace_pc, 32'h200 + popped);
                popped++;
            end
            if (pushed < 40) begin
                step(1'b1, 1'b0, 5'(pushed), 32'(pushed * 3), 32'h200 + pushed, rdy);
                pushed++;
            end else begin
                idle_step(rdy);
                pushed++;
            end
        end
        chk("wrap_count", popped, 32'd40);
        chk("wrap_drop", drop_count, 32'd0);

        // Randomized traffic in three occupancy regimes
        for (int ph = 0; ph < 3; ph++) begin
            int pv, pr;
            pv = (ph == 1) ? 85 : (ph == 2) ? 25 : 60;
            pr = (ph == 1) ? 20 : (ph == 2) ? 85 : 55;
            for (int c = 0; c < 600; c++) begin
                if ($urandom_range(0, 199) == 0) clear = 1'b1;
                if ($urandom_range(0, 399) == 0) reset = 1'b1;
                step($urandom_range(0, 99) < pv, 1'($urandom), 5'($urandom_range(0, 31)),
                     $urandom, $urandom, $urandom_range(0, 99) < pr);
                clear = 1'b0;
                reset = 1'b0;
            end
        end
        idle_step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
